// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, flag encoding and helpers for the small-float datapath
package fp_pkg;

  localparam int DEF_EXP_W = 4;
  localparam int DEF_MAN_W = 7;
  localparam int EXP_MAX   = (1 << DEF_EXP_W) - 1;
  localparam int SUM_W     = DEF_MAN_W + 2;

  // One-hot-free flag encoding: the result carries at most one flag
  typedef enum logic [1:0] {
    FLAG_NONE = 2'd0,
    FLAG_ZERO = 2'd1,
    FLAG_OVF  = 2'd2,
    FLAG_UNF  = 2'd3
  } flag_e;

  // Raw significand sum width: carry + hidden bit + stored mantissa
  function automatic int sum_w(input int man_w);
    return man_w + 2;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter, all-zero input returns W
module fp_lzc #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] cnt
);

  // Scan from the LSB upward so the highest set bit is the last to write the count
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - 2-stage normaliser/exponent generator, optional FP_NORM_ROUND_EN rounding
module fp_norm_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_xe_lt_ye,
  input  logic [EXP_W-1:0]       in_xe,
  input  logic [EXP_W-1:0]       in_ye,
  input  logic [MAN_W+1:0]       in_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       out_ze,
  output logic [MAN_W-1:0]       out_zm,
  output logic                   out_zero,
  output logic                   out_ovf,
  output logic                   out_unf
);

  localparam int SW   = sum_w(MAN_W);
  localparam int LZ_W = $clog2(MAN_W + 2);
  localparam int XW   = EXP_W + 1;

  logic            s1_valid;
  logic [EXP_W-1:0] s1_ge;
  logic [SW-1:0]   s1_sum;
  logic [LZ_W-1:0] s1_lzc;
  logic            s2_valid;
  flag_e           s2_flag;

  logic            s1_adv;
  logic            s2_adv;
  logic [EXP_W-1:0] ge_in;
  logic [LZ_W-1:0] lzc_in;

  logic [XW-1:0]   ge_x;
  logic [XW-1:0]   ze_carry;
  logic [XW-1:0]   ze_shift;
  logic [MAN_W-1:0] zm_carry;
  logic [MAN_W-1:0] zm_shift;
  logic [EXP_W-1:0] nxt_ze;
  logic [MAN_W-1:0] nxt_zm;
  flag_e           nxt_flag;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign ge_in    = in_xe_lt_ye ? in_ye : in_xe;

  fp_lzc #(.W(MAN_W + 1), .CNT_W(LZ_W)) u_lzc (
    .din (in_sum[MAN_W:0]),
    .cnt (lzc_in)
  );

  // Stage 1: capture the larger exponent, raw sum and its leading-zero count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ge    <= '0;
      s1_sum   <= '0;
      s1_lzc   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ge  <= ge_in;
        s1_sum <= in_sum;
        s1_lzc <= lzc_in;
      end
    end
  end

  // Stage 2 datapath: carry right-shift, zero, flush-to-zero underflow or left normalise
  always_comb begin
    ge_x     = {1'b0, s1_ge};
    zm_carry = s1_sum[MAN_W:1];
    ze_carry = ge_x + XW'(1);
`ifdef FP_NORM_ROUND_EN
    // Round half to even on the single dropped bit; a wrap bumps the exponent again
    if (s1_sum[0] && s1_sum[1]) begin
      if (&zm_carry) ze_carry = ze_carry + XW'(1);
      zm_carry = zm_carry + MAN_W'(1);
    end
`endif
    ze_shift = ge_x - XW'(s1_lzc);
    // Bit MAN_W is the hidden bit and always shifts out of the stored mantissa
    zm_shift = s1_sum[MAN_W-1:0] << s1_lzc;

    nxt_ze   = '0;
    nxt_zm   = '0;
    nxt_flag = FLAG_NONE;
    if (s1_sum[MAN_W+1]) begin
      if (ze_carry[EXP_W]) begin
        nxt_flag = FLAG_OVF;
        nxt_ze   = '1;
      end else begin
        nxt_ze = ze_carry[EXP_W-1:0];
        nxt_zm = zm_carry;
      end
    end else if (s1_sum[MAN_W:0] == '0) begin
      nxt_flag = FLAG_ZERO;
    end else if (ze_shift[EXP_W]) begin
      nxt_flag = FLAG_UNF;
    end else begin
      nxt_ze = ze_shift[EXP_W-1:0];
      nxt_zm = zm_shift;
    end
  end

  // Stage 2 register: result holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_ze   <= '0;
      out_zm   <= '0;
      s2_flag  <= FLAG_NONE;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_ze  <= nxt_ze;
        out_zm  <= nxt_zm;
        s2_flag <= nxt_flag;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_zero  = (s2_flag == FLAG_ZERO);
  assign out_ovf   = (s2_flag == FLAG_OVF);
  assign out_unf   = (s2_flag == FLAG_UNF);

endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb/tb_fp_norm_pipe.sv - self-checking bench for fp_norm_pipe with reference model and scoreboard
module tb_fp_norm_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_xe_lt_ye = 1'b0;
  logic [3:0] in_xe = '0;
  logic [3:0] in_ye = '0;
  logic [8:0] in_sum = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_ze;
  logic [6:0] out_zm;
  logic       out_zero;
  logic       out_ovf;
  logic       out_unf;

  typedef struct packed {
    logic [3:0] ze;
    logic [6:0] zm;
    logic       zero;
    logic       ovf;
    logic       unf;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t held;
  bit   stall_prev = 1'b0;

  fp_norm_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_xe_lt_ye(in_xe_lt_ye),
    .in_xe      (in_xe),
    .in_ye      (in_ye),
    .in_sum     (in_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ze     (out_ze),
    .out_zm     (out_zm),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, normalising by repeated doubling
  function automatic res_t model(input int xe, input int ye, input bit lt, input int sum);
    res_t r;
    int   ge;
    int   e;
    int   m;
    r  = '0;
    ge = lt ? ye : xe;
    if (sum >= 256) begin
      m = (sum / 2) % 128;
      e = ge + 1;
`ifdef FP_NORM_ROUND_EN
      if ((sum % 4) == 3) begin
        m = m + 1;
        if (m == 128) begin
          m = 0;
          e = e + 1;
        end
      end
`endif
      if (e > 15) begin
        r.ovf = 1'b1;
        r.ze  = 4'd15;
      end else begin
        r.ze = 4'(e);
        r.zm = 7'(m);
      end
    end else if (sum == 0) begin
      r.zero = 1'b1;
    end else begin
      m = sum;
      e = ge;
      while (m < 128) begin
        m = m * 2;
        e = e - 1;
      end
      if (e < 0) begin
        r.unf = 1'b1;
      end else begin
        r.ze = 4'(e);
        r.zm = 7'(m - 128);
      end
    end
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.ze   = out_ze;
    r.zm   = out_zm;
    r.zero = out_zero;
    r.ovf  = out_ovf;
    r.unf  = out_unf;
    return r;
  endfunction

  task automatic chk_res(input string name, input res_t act, input res_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got ze=%0d zm=%b z/o/u=%b%b%b, want ze=%0d zm=%b z/o/u=%b%b%b",
               name, act.ze, act.zm, act.zero, act.ovf, act.unf,
               exp.ze, exp.zm, exp.zero, exp.ovf, exp.unf);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Scoreboard step, run once per negedge: stability, in-order output, capture accepted input
  task automatic sb_step();
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) chk_res("stall_hold", dut_res(), held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got ze=%0d zm=%b, want no beat", out_ze, out_zm);
        end else begin
          e = exp_q.pop_front();
          chk_res("beat", dut_res(), e);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(int'(in_xe), int'(in_ye), in_xe_lt_ye, int'(in_sum)));
      stall_prev = out_valid && !out_ready;
      held = dut_res();
    end
  endtask

  task automatic half();
    @(negedge clk);
    sb_step();
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int xe, input int ye, input bit lt, input int sum);
    bit acc;
    int n;
    in_xe       = 4'(xe);
    in_ye       = 4'(ye);
    in_xe_lt_ye = lt;
    in_sum      = 9'(sum);
    in_valid    = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      half();
      acc = in_ready;
      edge_();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      half();
      edge_();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d beats outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    res_t lit;

    // Hand-computed values pinning the model to the worked examples
`ifdef FP_NORM_ROUND_EN
    lit = '{ze: 4'd6, zm: 7'b0110110, zero: 1'b0, ovf: 1'b0, unf: 1'b0};
`else
    lit = '{ze: 4'd6, zm: 7'b0110101, zero: 1'b0, ovf: 1'b0, unf: 1'b0};
`endif
    chk_res("pin_carry", model(5, 3, 1'b0, 9'h16B), lit);
    lit = '{ze: 4'd4, zm: 7'b0100000, zero: 1'b0, ovf: 1'b0, unf: 1'b0};
    chk_res("pin_lshift", model(2, 7, 1'b1, 9'h014), lit);
    lit = '{ze: 4'd3, zm: 7'b0000001, zero: 1'b0, ovf: 1'b0, unf: 1'b0};
    chk_res("pin_noshift", model(3, 0, 1'b0, 9'h081), lit);
    lit = '{ze: 4'd0, zm: 7'd0, zero: 1'b0, ovf: 1'b0, unf: 1'b1};
    chk_res("pin_unf", model(2, 0, 1'b0, 9'h002), lit);
    lit = '{ze: 4'd0, zm: 7'd0, zero: 1'b1, ovf: 1'b0, unf: 1'b0};
    chk_res("pin_zero", model(2, 0, 1'b0, 0), lit);
    lit = '{ze: 4'd15, zm: 7'd0, zero: 1'b0, ovf: 1'b1, unf: 1'b0};
    chk_res("pin_ovf", model(15, 0, 1'b0, 9'h100), lit);
`ifdef FP_NORM_ROUND_EN
    lit = '{ze: 4'd15, zm: 7'd0, zero: 1'b0, ovf: 1'b1, unf: 1'b0};
`else
    lit = '{ze: 4'd15, zm: 7'b1111111, zero: 1'b0, ovf: 1'b0, unf: 1'b0};
`endif
    chk_res("pin_round_wrap", model(14, 0, 1'b0, 9'h1FF), lit);

    // Reset state
    half();
    chk_bit("rst_out_valid", out_valid, 1'b0);
    lit = '0;
    chk_res("rst_outputs", dut_res(), lit);
    edge_();
    rst_n = 1'b1;
    edge_();
    half();
    chk_bit("rst_in_ready", in_ready, 1'b1);
    edge_();

    // Directed vectors, streamed back to back
    send(5, 3, 1'b0, 9'h16B);
    send(2, 7, 1'b1, 9'h014);
    send(3, 0, 1'b0, 9'h081);
    send(2, 0, 1'b0, 9'h002);
    send(2, 0, 1'b0, 9'h000);
    send(15, 0, 1'b0, 9'h100);
    send(14, 0, 1'b0, 9'h1FF);
    send(3, 9, 1'b1, 9'h010);
    send(0, 9, 1'b1, 9'h001);
    send(0, 8, 1'b1, 9'h001);
    send(3, 1, 1'b0, 9'h100);
    send(7, 2, 1'b0, 9'h0FF);
    drain();

    // Backpressure: two beats fill the pipe, the third waits
    out_ready = 1'b0;
    send(4, 0, 1'b0, 9'h0C5);
    send(6, 0, 1'b0, 9'h13B);
    in_xe = 4'd9; in_ye = 4'd0; in_xe_lt_ye = 1'b0; in_sum = 9'h033; in_valid = 1'b1;
    half();
    chk_bit("bp_in_ready_low", in_ready, 1'b0);
    chk_bit("bp_out_valid", out_valid, 1'b1);
    edge_();
    half();
    chk_bit("bp_still_full", in_ready, 1'b0);
    edge_();
    half();
    edge_();
    out_ready = 1'b1;
    send(9, 0, 1'b0, 9'h033);
    send(1, 12, 1'b1, 9'h1AA);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(5, 0, 1'b0, 9'h0AA);
    send(5, 0, 1'b0, 9'h055);
    half();
    chk_bit("pre_rst_full", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("async_rst_out_valid", out_valid, 1'b0);
    lit = '0;
    chk_res("async_rst_outputs", dut_res(), lit);
    edge_();
    half();
    edge_();
    rst_n = 1'b1;
    out_ready = 1'b1;
    edge_();
    half();
    chk_bit("post_rst_in_ready", in_ready, 1'b1);
    edge_();
    send(8, 0, 1'b0, 9'h040);
    half();
    chk_bit("lat_cycle1_idle", out_valid, 1'b0);
    edge_();
    half();
    chk_bit("lat_cycle2_valid", out_valid, 1'b1);
    edge_();
    drain();
    repeat (3) begin
      half();
      edge_();
    end
    chk_bit("no_stale_beat", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
